// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline constants and hazard-controller state encoding.
package hazard_stall_ctrl_pkg;

  // MIPS-style opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LW    = 6'h23;

  // Instruction field slices
  localparam int unsigned OP_HI = 31;
  localparam int unsigned OP_LO = 26;
  localparam int unsigned RS_HI = 25;
  localparam int unsigned RS_LO = 21;
  localparam int unsigned RT_HI = 20;
  localparam int unsigned RT_LO = 16;

  localparam int unsigned FC_W   = 3;
  localparam int unsigned WAIT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      if_id_instruction;
  logic [31:0]      id_ex_instruction;
  logic             id_ex_MemRead;
  logic             ex_mem_branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             stall;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             pipe_hold;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             mem_err;

  // Pipeline side
  modport master (
    output if_id_instruction, id_ex_instruction, id_ex_MemRead,
           ex_mem_branch_taken, dmem_req, dmem_ready,
    input  stall, pc_write, if_id_write, if_id_flush, pipe_hold,
           stall_count, flush_count, mem_err
  );

  // Controller side
  modport slave (
    input  if_id_instruction, id_ex_instruction, id_ex_MemRead,
           ex_mem_branch_taken, dmem_req, dmem_ready,
    output stall, pc_write, if_id_write, if_id_flush, pipe_hold,
           stall_count, flush_count, mem_err
  );
endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, updated on the falling edge.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Count up, hold at all-ones
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)               q <= '0;
    else if (clr)             q <= '0;
    else if (inc && q != '1)  q <= q + W'(1);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-flush / memory-wait hazard controller.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_LEN   = 3,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input logic              clk,
  input logic              rst_n,
  hazard_stall_ctrl_if.slave bus
);

  localparam logic [FC_W-1:0]   FLUSH_RELOAD = FC_W'(FLUSH_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX     = WAIT_W'(MEM_TIMEOUT);

  state_t            state, state_nxt;
  logic [FC_W-1:0]   flush_cnt, flush_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_q, flush_q;
  logic              mem_err_q, err_set;
  logic              stall_inc, flush_inc, wait_inc, wait_clr;
  logic              stall_c, pc_write_c, if_id_write_c, if_id_flush_c, pipe_hold_c;
  logic              mem_block, uses_rt, lu_hazard;
  logic [5:0]        id_op;
  logic [4:0]        id_rs, id_rt, ex_rt;

  // Decode fields and detect a load-use dependency
  always_comb begin
    id_op     = bus.if_id_instruction[OP_HI:OP_LO];
    id_rs     = bus.if_id_instruction[RS_HI:RS_LO];
    id_rt     = bus.if_id_instruction[RT_HI:RT_LO];
    ex_rt     = bus.id_ex_instruction[RT_HI:RT_LO];
    uses_rt   = (id_op == OP_RTYPE) || (id_op == OP_BEQ) ||
                (id_op == OP_BNE)   || (id_op == OP_SW);
    lu_hazard = bus.id_ex_MemRead && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    mem_block = bus.dmem_req && !bus.dmem_ready;
  end

  // Next-state and combinational outputs; priority mem wait > flush > load-use
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    wait_inc      = 1'b0;
    wait_clr      = 1'b0;
    stall_c       = 1'b0;
    pc_write_c    = 1'b0;
    if_id_write_c = 1'b0;
    if_id_flush_c = 1'b0;
    pipe_hold_c   = 1'b0;
    err_set       = 1'b0;
    case (state)
      ST_RUN, ST_FLUSH: begin
        if (mem_block) begin
          pipe_hold_c = 1'b1;
          wait_inc    = 1'b1;
          state_nxt   = ST_MEM_WAIT;
        end else if (bus.ex_mem_branch_taken) begin
          if_id_flush_c = 1'b1;
          stall_c       = 1'b1;
          pc_write_c    = 1'b1;
          if_id_write_c = 1'b1;
          flush_inc     = 1'b1;
          flush_cnt_nxt = FLUSH_RELOAD;
          state_nxt     = (FLUSH_RELOAD != '0) ? ST_FLUSH : ST_RUN;
        end else if (state == ST_FLUSH) begin
          if_id_flush_c = 1'b1;
          stall_c       = 1'b1;
          pc_write_c    = 1'b1;
          if_id_write_c = 1'b1;
          flush_cnt_nxt = flush_cnt - FC_W'(1);
          if (flush_cnt == FC_W'(1)) state_nxt = ST_RUN;
        end else if (lu_hazard) begin
          stall_c   = 1'b1;
          stall_inc = 1'b1;
        end else begin
          pc_write_c    = 1'b1;
          if_id_write_c = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        pipe_hold_c = 1'b1;
        err_set     = (wait_cnt >= WAIT_MAX);
        if (bus.dmem_ready) begin
          wait_clr  = 1'b1;
          state_nxt = (flush_cnt != '0) ? ST_FLUSH : ST_RUN;
        end else begin
          wait_inc = (wait_cnt < WAIT_MAX);
        end
      end
      default: state_nxt = ST_RUN;
    endcase
    // Hold the pipe in a safe bubble while reset is asserted
    if (!rst_n) begin
      stall_c       = 1'b1;
      pc_write_c    = 1'b0;
      if_id_write_c = 1'b0;
      if_id_flush_c = 1'b1;
      pipe_hold_c   = 1'b0;
    end
  end

  // State, flush countdown and sticky timeout flag
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      if (err_set) mem_err_q <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(stall_inc), .clr(1'b0), .q(stall_q)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(flush_inc), .clr(1'b0), .q(flush_q)
  );

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk(clk), .rst_n(rst_n), .inc(wait_inc), .clr(wait_clr), .q(wait_cnt)
  );

  assign bus.stall       = stall_c;
  assign bus.pc_write    = pc_write_c;
  assign bus.if_id_write = if_id_write_c;
  assign bus.if_id_flush = if_id_flush_c;
  assign bus.pipe_hold   = pipe_hold_c;
  assign bus.stall_count = stall_q;
  assign bus.flush_count = flush_q;
  assign bus.mem_err     = mem_err_q;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller that produces the `stall` input consumed by the ID/EX register, plus the PC and IF/ID write enables and the flush strobes.
- Detects load-use hazards between IF/ID and ID/EX.
- Sequences a multi-cycle flush after a taken branch resolved in MEM.
- Freezes the whole pipe while the data memory handshake is pending.
- Keeps stall/flush performance counters and a sticky memory-timeout error.

Parameters:
- FLUSH_LEN, 3: cycles of IF/ID + ID/EX flush after a taken branch (1..7).
- MEM_TIMEOUT, 255: max consecutive memory-wait cycles before `mem_err` sets (1..65535).
- CNT_W, 16: performance counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on the negative edge, matching the pipeline registers.
- rst_n  in  1  asynchronous active-low reset.
- if_id_instruction  in  32  instruction in decode.
- id_ex_instruction  in  32  instruction in execute.
- id_ex_MemRead  in  1  EX-stage load flag.
- ex_mem_branch_taken  in  1  taken branch resolved in MEM, 1-cycle pulse.
- dmem_req  in  1  MEM-stage access active (MemRead|MemWrite).
- dmem_ready  in  1  data memory completes the access this cycle.
- stall  out  1  to ID/EX: insert bubble (zero control fields).
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID update enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB.
- stall_count  out  CNT_W  load-use bubbles inserted.
- flush_count  out  CNT_W  taken-branch flush events.
- mem_err  out  1  sticky memory timeout.

Behaviour:
- Field slices: rs = [25:21], rt = [20:16], opcode = [31:26].
- `uses_rt`: IF/ID opcode is 0x00, 0x04, 0x05 or 0x2B.
- `lu_hazard` = id_ex_MemRead && ex_rt != 0 && (ex_rt == id_rs || (uses_rt && ex_rt == id_rt)). Combinational.
- Reset (rst_n = 0, asynchronous):
  - state = RUN, counters = 0, mem_err = 0, flush_cnt = 0, wait_cnt = 0.
  - Outputs forced: stall = 1, pc_write = 0, if_id_write = 0, if_id_flush = 1, pipe_hold = 0.
- States: RUN, FLUSH, MEM_WAIT.
- Priority within any cycle: memory wait > branch flush > load-use.
- RUN, with outputs computed combinationally from inputs:
  - dmem_req && !dmem_ready: pipe_hold = 1, pc_write = 0, if_id_write = 0, stall = 0. Next state MEM_WAIT, wait_cnt = 1.
  - Else ex_mem_branch_taken: if_id_flush = 1, stall = 1, pc_write = 1 (branch target loads). Next state FLUSH, flush_cnt = FLUSH_LEN-1, flush_count += 1. With FLUSH_LEN = 1, stay in RUN.
  - Else lu_hazard: stall = 1, pc_write = 0, if_id_write = 0. stall_count += 1. Single cycle, no state change; the bubble clears the hazard on the next cycle.
  - Else: pc_write = 1, if_id_write = 1, all other outputs 0.
- FLUSH:
  - if_id_flush = 1, stall = 1, pc_write = 1, if_id_write = 1.
  - flush_cnt decrements each cycle; return to RUN after the cycle where it reaches 0.
  - lu_hazard is ignored.
  - A new ex_mem_branch_taken reloads flush_cnt = FLUSH_LEN-1 and increments flush_count.
  - dmem_req && !dmem_ready goes to MEM_WAIT; the remaining flush_cnt is kept and FLUSH resumes afterwards.
- MEM_WAIT:
  - pipe_hold = 1, pc_write = 0, if_id_write = 0, stall = 0, if_id_flush = 0.
  - wait_cnt increments, saturating at MEM_TIMEOUT.
  - When wait_cnt reaches MEM_TIMEOUT, set mem_err (sticky until reset); stay waiting.
  - dmem_ready = 1: outputs that cycle are as in the wait; exit to FLUSH if flush_cnt != 0, else RUN.
  - ex_mem_branch_taken is frozen in EX/MEM while waiting and is acted on after exit.
- Counters saturate at all-ones; they never wrap.
- Reset asserted mid-FLUSH or mid-MEM_WAIT aborts immediately to the reset values.

Decomposition:
- Shared pipeline package holds:
  - opcode constants OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_LW;
  - field-slice constants RS_HI/RS_LO, RT_HI/RT_LO;
  - the 2-bit state encoding.
- One sub-module, `sat_counter` (parameter W; inc, clr, q), instanced for stall_count, flush_count and wait_cnt.

Test Plan:
1. lw $2 in ID/EX (id_ex_MemRead = 1, rt = 2), add $3,$2,$4 in IF/ID -> stall = 1, pc_write = 0, if_id_write = 0 for exactly 1 cycle; stall_count = 1.
2. lw $0 in ID/EX with a consumer reading $0 -> no stall. addi using rt = 2 as destination (uses_rt = 0) -> no stall.
3. ex_mem_branch_taken pulse, FLUSH_LEN = 3 -> if_id_flush = 1 and stall = 1 for 3 consecutive cycles; flush_count = 1. A simultaneous lu_hazard must not increment stall_count.
4. dmem_req = 1, dmem_ready = 0 for 5 cycles then 1 -> pipe_hold = 1 for 6 cycles, pc_write = 0 throughout, mem_err = 0. With MEM_TIMEOUT = 4 and the same stimulus -> mem_err = 1 and it stays set.
5. Branch flush with 1 cycle done, then a 2-cycle memory wait -> wait honoured, then 2 remaining flush cycles, then RUN.
6. rst_n low mid-MEM_WAIT -> outputs take the reset values at once; after release, RUN with pc_write = 1 and counters = 0.
